// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//   Shares one slow line-oriented memory between NUM_CH cache channels.
//   Requests are arbitrated round-robin (PRIO_MODE=0) or by fixed priority
//   with channel 0 highest (PRIO_MODE=1). The winner's address, write line and
//   read/write kind are latched, presented to memory for the whole BUSY phase,
//   and completion is signalled by a one-cycle ch_ready pulse to the winner.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   ch_read / ch_write      per-channel line read / write request
//   ch_addr                 per-channel line address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata                per-channel write line, channel i at [i*LINE_W +: LINE_W]
//   ch_rdata                last line read from memory, broadcast to all channels
//   ch_ready                one-cycle completion pulse for the granted channel
//   mem_read / mem_write    command to memory, exactly one high while BUSY
//   mem_addr / mem_wdata    latched address / write line for memory
//   mem_rdata / mem_ready   read line and completion strobe from memory
//   grant_id                index of the channel owning (or last owning) memory
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int  NUM_CH    = 2,
    parameter int  ADDR_W    = 28,
    parameter int  LINE_W    = 128,
    parameter int  PRIO_MODE = 0,
    localparam int GID_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic [LINE_W-1:0]          mem_rdata,
    input  logic                       mem_ready,
    output logic [GID_W-1:0]           grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q,      state_d;
    logic [GID_W-1:0]    gid_q,        gid_d;
    logic [GID_W-1:0]    last_grant_q, last_grant_d;
    logic                is_write_q,   is_write_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [LINE_W-1:0]   wdata_q,      wdata_d;
    logic [LINE_W-1:0]   rdata_q,      rdata_d;

    logic [NUM_CH-1:0]   req;
    int                  win;

    // Winner selection. Descending loops let the last hit (the one with the
    // smallest search distance) win without needing an early exit.
    function automatic int pick_winner(input logic [NUM_CH-1:0] r, input int last);
        int w;
        int idx;
        w = 0;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if ((r & (NUM_CH'(1) << i)) != '0) w = i;
            end
        end else begin
            // Search starts one past the previous winner and wraps around.
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = last + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if ((r & (NUM_CH'(1) << idx)) != '0) w = idx;
            end
        end
        return w;
    endfunction

    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        req          = ch_read | ch_write;
        win          = pick_winner(req, int'(last_grant_q));

        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d      = ST_BUSY;
                    gid_d        = GID_W'(win);
                    last_grant_d = GID_W'(win);
                    // A channel raising both read and write is served as a write.
                    is_write_d   = (ch_write & (NUM_CH'(1) << win)) != '0;
                    addr_d       = ADDR_W'(ch_addr >> (win * ADDR_W));
                    wdata_d      = LINE_W'(ch_wdata >> (win * LINE_W));
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    if (!is_write_q) rdata_d = mem_rdata;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    // NOTE: the wide data registers are reset too, because the memory-side and
    // read-data outputs must read as zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gid_q        <= '0;
            last_grant_q <= GID_W'(NUM_CH - 1);
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode registered state only, so they are glitch-free and
    // stable for the whole BUSY phase.
    always_comb begin
        ch_ready = '0;
        if (state_q == ST_RESP) ch_ready = NUM_CH'(1) << gid_q;
    end

    assign mem_read  = (state_q == ST_BUSY) && !is_write_q;
    assign mem_write = (state_q == ST_BUSY) &&  is_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ch_rdata  = rdata_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_rr
//   Three arbiter instances: two 2-channel ones (round-robin and fixed
//   priority) driven by directed sequences, and a 4-channel round-robin one
//   driven by random traffic. Expected transactions are queued when stimulus
//   is applied and compared when the arbiter grants and completes them.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

    typedef struct {
        int           ch;
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;   // write line, or expected read line
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed A5 line at 0x123, otherwise address-derived.
    function automatic logic [127:0] mem_line(input logic [27:0] a);
        if (a == 28'h0000123) return {16{8'hA5}};
        return {a, 4'h0, ~a, 4'hF, a ^ 28'h5A5A5A5, 4'h5, a + 28'd7, 4'hA};
    endfunction

    // ---------------- two-channel instances (0: round-robin, 1: fixed) -------
    logic [1:0]   rd_a[2], wr_a[2], rdy_a[2];
    logic [55:0]  addr_a[2];
    logic [255:0] wdata_a[2];
    logic [127:0] rdata_a[2], mwdata_a[2], mrdata_a[2];
    logic         mrd_a[2], mwr_a[2], mready_a[2], gid_a[2];
    logic [27:0]  maddr_a[2];

    for (genvar p = 0; p < 2; p++) begin : g_two
        mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(28), .LINE_W(128), .PRIO_MODE(p)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ch_read(rd_a[p]), .ch_write(wr_a[p]), .ch_addr(addr_a[p]), .ch_wdata(wdata_a[p]),
            .ch_rdata(rdata_a[p]), .ch_ready(rdy_a[p]),
            .mem_read(mrd_a[p]), .mem_write(mwr_a[p]), .mem_addr(maddr_a[p]), .mem_wdata(mwdata_a[p]),
            .mem_rdata(mrdata_a[p]), .mem_ready(mready_a[p]), .grant_id(gid_a[p])
        );
    end

    // ---------------- four-channel round-robin instance ----------------------
    logic [3:0]   rd4, wr4, rdy4;
    logic [111:0] addr4;
    logic [511:0] wdata4;
    logic [127:0] rdata4, mwdata4, mrdata4;
    logic         mrd4, mwr4, mready4;
    logic [27:0]  maddr4;
    logic [1:0]   gid4;

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(28), .LINE_W(128), .PRIO_MODE(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .ch_read(rd4), .ch_write(wr4), .ch_addr(addr4), .ch_wdata(wdata4),
        .ch_rdata(rdata4), .ch_ready(rdy4),
        .mem_read(mrd4), .mem_write(mwr4), .mem_addr(maddr4), .mem_wdata(mwdata4),
        .mem_rdata(mrdata4), .mem_ready(mready4), .grant_id(gid4)
    );

    // ---------------- memory responders --------------------------------------
    int lat2[2], cnt2[2], spur2[2];
    int lat4 = 1, cnt4 = 0;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (mrd_a[p] || mwr_a[p]) begin
                if (cnt2[p] >= lat2[p]) begin
                    mready_a[p] = 1'b1;
                    mrdata_a[p] = mem_line(maddr_a[p]);
                end else begin
                    mready_a[p] = 1'b0;
                    mrdata_a[p] = {4{32'hDEAD_BEEF}};
                    cnt2[p]++;
                end
            end else begin
                cnt2[p]     = 0;
                mready_a[p] = (spur2[p] != 0);
                mrdata_a[p] = {128{1'b1}};
            end
        end
    end

    always @(negedge clk) begin
        if (mrd4 || mwr4) begin
            if (cnt4 >= lat4) begin
                mready4 = 1'b1;
                mrdata4 = mem_line(maddr4);
                lat4    = $urandom_range(0, 3);
            end else begin
                mready4 = 1'b0;
                mrdata4 = {4{32'hDEAD_BEEF}};
                cnt4++;
            end
        end else begin
            cnt4    = 0;
            mready4 = 1'b0;
            mrdata4 = '0;
        end
    end

    // ---------------- monitors / scoreboards ---------------------------------
    txn_t         exp2[2][$];
    int           done2[2][2];
    bit           busy_prev2[2];
    logic [27:0]  hold_addr2[2];
    logic         hold_gid2[2];
    logic [127:0] last_rd2[2];

    always @(negedge clk) begin
        txn_t e;
        bit   busy;
        for (int p = 0; p < 2; p++) begin
            if (!rst_n) begin
                busy_prev2[p] = 1'b0;
                last_rd2[p]   = '0;
            end else begin
                busy = mrd_a[p] || mwr_a[p];
                if (busy && !busy_prev2[p]) begin
                    if (exp2[p].size() == 0) check("unexpected_grant", 1, 0);
                    else begin
                        e = exp2[p][0];
                        check("grant_id", gid_a[p], e.ch);
                        check("mem_write", mwr_a[p], e.wr);
                        check("mem_read", mrd_a[p], !e.wr);
                        check("mem_addr", maddr_a[p], e.addr);
                        if (e.wr) check("mem_wdata", mwdata_a[p], e.data);
                    end
                    hold_addr2[p] = maddr_a[p];
                    hold_gid2[p]  = gid_a[p];
                end else if (busy) begin
                    check("addr_stable", maddr_a[p], hold_addr2[p]);
                    check("gid_stable", gid_a[p], hold_gid2[p]);
                end
                if (rdy_a[p] != 2'b00) begin
                    check("resp_mem_idle", mrd_a[p] || mwr_a[p], 0);
                    if (exp2[p].size() == 0) check("unexpected_ready", rdy_a[p], 0);
                    else begin
                        e = exp2[p].pop_front();
                        check("ch_ready", rdy_a[p], 2'b01 << e.ch);
                        check("resp_gid", gid_a[p], e.ch);
                        if (!e.wr) begin
                            check("rd_data", rdata_a[p], e.data);
                            last_rd2[p] = e.data;
                        end else begin
                            check("wr_keeps_rdata", rdata_a[p], last_rd2[p]);
                        end
                        done2[p][e.ch]++;
                    end
                end
                busy_prev2[p] = busy;
            end
        end
    end

    txn_t         exp4[4][$];
    int           comp4[4], skip4[4];
    bit           granted4[4];
    bit           busy_prev4;
    logic [127:0] last_rd4;

    always @(negedge clk) begin
        txn_t e;
        bit   busy;
        int   g;
        if (!rst_n) begin
            busy_prev4 = 1'b0;
            last_rd4   = '0;
            for (int c = 0; c < 4; c++) begin
                granted4[c] = 1'b0;
                skip4[c]    = 0;
            end
        end else begin
            busy = mrd4 || mwr4;
            if (busy && !busy_prev4) begin
                g = int'(gid4);
                for (int c = 0; c < 4; c++)
                    if (c != g && exp4[c].size() != 0 && !granted4[c]) skip4[c]++;
                if (exp4[g].size() == 0) check("r4_unexpected_grant", 1, 0);
                else begin
                    e = exp4[g][0];
                    check("r4_kind", mwr4, e.wr);
                    check("r4_addr", maddr4, e.addr);
                    if (e.wr) check("r4_wdata", mwdata4, e.data);
                    check("r4_starve_bound", skip4[g] <= 3, 1);
                end
                granted4[g] = 1'b1;
                skip4[g]    = 0;
            end
            if (rdy4 != 4'b0000) begin
                g = int'(gid4);
                check("r4_onehot", $countones(rdy4), 1);
                check("r4_ready_bit", rdy4, 4'b0001 << g);
                if (exp4[g].size() == 0) check("r4_unexpected_ready", 1, 0);
                else begin
                    e = exp4[g].pop_front();
                    if (!e.wr) begin
                        check("r4_rd_data", rdata4, e.data);
                        last_rd4 = e.data;
                    end else begin
                        check("r4_wr_keeps_rdata", rdata4, last_rd4);
                    end
                    comp4[g]++;
                end
                granted4[g] = 1'b0;
            end
            busy_prev4 = busy;
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int p, input int ch, input int target,
                             input string tag, output int waited);
        waited = 0;
        while (done2[p][ch] < target && waited < 200) begin
            tick(1);
            waited++;
        end
        if (done2[p][ch] < target) check({tag, "_timeout"}, done2[p][ch], target);
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        txn_t t;
        int   w, base0, base1, issued4, kind, sum4, guard;
        bit   active4[4];
        int   seen4[4];

        for (int p = 0; p < 2; p++) begin
            rd_a[p] = '0; wr_a[p] = '0; addr_a[p] = '0; wdata_a[p] = '0;
            lat2[p] = 1;  spur2[p] = 0;
        end
        rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
        issued4 = 0;
        for (int c = 0; c < 4; c++) begin
            active4[c] = 1'b0;
            seen4[c]   = 0;
        end

        // Reset values
        tick(3);
        check("rst_mem_read", mrd_a[0], 0);
        check("rst_mem_write", mwr_a[0], 0);
        check("rst_mem_addr", maddr_a[0], 0);
        check("rst_mem_wdata", mwdata_a[0], 0);
        check("rst_ch_ready", rdy_a[0], 0);
        check("rst_ch_rdata", rdata_a[0], 0);
        check("rst_grant_id", gid_a[0], 0);
        check("rst4_grant_id", gid4, 0);
        rst_n = 1'b1;
        tick(2);

        // Single read on channel 0, memory answers in the 4th BUSY cycle
        lat2[0] = 3;
        exp2[0].push_back('{0, 1'b0, 28'h0000123, {16{8'hA5}}});
        addr_a[0][27:0] = 28'h0000123;
        rd_a[0] = 2'b01;
        tick(1);
        check("rd_latency", mrd_a[0], 1);
        wait_done(0, 0, 1, "single_read", w);
        check("rd_turnaround", w, 4);
        rd_a[0] = 2'b00;
        tick(1);
        check("ready_one_cycle", rdy_a[0], 0);

        // Write on channel 1 leaves ch_rdata alone
        lat2[0] = 1;
        exp2[0].push_back('{1, 1'b1, 28'h0000456, 128'h0123456789ABCDEF0123456789ABCDEF});
        addr_a[0][55:28]   = 28'h0000456;
        wdata_a[0][255:128] = 128'h0123456789ABCDEF0123456789ABCDEF;
        wr_a[0] = 2'b10;
        wait_done(0, 1, 1, "write", w);
        wr_a[0] = 2'b00;
        tick(1);
        check("rdata_after_write", rdata_a[0], {16{8'hA5}});

        // Read and write together on channel 0 is served as a write
        exp2[0].push_back('{0, 1'b1, 28'h0000789, {4{32'hCAFE_F00D}}});
        addr_a[0][27:0]   = 28'h0000789;
        wdata_a[0][127:0] = {4{32'hCAFE_F00D}};
        rd_a[0] = 2'b01; wr_a[0] = 2'b01;
        wait_done(0, 0, 2, "rw_both", w);
        rd_a[0] = 2'b00; wr_a[0] = 2'b00;
        tick(1);

        // Spurious mem_ready while idle
        spur2[0] = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("spur_no_ready", rdy_a[0], 0);
            check("spur_mem_idle", mrd_a[0] || mwr_a[0], 0);
        end
        spur2[0] = 0;
        tick(1);
        exp2[0].push_back('{1, 1'b0, 28'h0000ABC, mem_line(28'h0000ABC)});
        addr_a[0][55:28] = 28'h0000ABC;
        rd_a[0] = 2'b10;
        wait_done(0, 1, 2, "after_spur", w);
        rd_a[0] = 2'b00;
        tick(1);

        // Round-robin from a fresh reset, both channels reading continuously
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        base1 = done2[0][1];
        addr_a[0] = {28'h0002000, 28'h0001000};
        for (int i = 0; i < 2; i++) begin
            exp2[0].push_back('{0, 1'b0, 28'h0001000, mem_line(28'h0001000)});
            exp2[0].push_back('{1, 1'b0, 28'h0002000, mem_line(28'h0002000)});
        end
        rd_a[0] = 2'b11;
        wait_done(0, 1, base1 + 2, "rr", w);
        rd_a[0] = 2'b00;
        tick(2);
        check("rr_all_served", exp2[0].size(), 0);

        // Fixed priority: channel 0 wins until it drops
        base0 = done2[1][0];
        base1 = done2[1][1];
        addr_a[1] = {28'h0002000, 28'h0001000};
        for (int i = 0; i < 3; i++)
            exp2[1].push_back('{0, 1'b0, 28'h0001000, mem_line(28'h0001000)});
        exp2[1].push_back('{1, 1'b0, 28'h0002000, mem_line(28'h0002000)});
        rd_a[1] = 2'b11;
        wait_done(1, 0, base0 + 3, "prio_ch0", w);
        rd_a[1] = 2'b10;
        wait_done(1, 1, base1 + 1, "prio_ch1", w);
        rd_a[1] = 2'b00;
        tick(2);
        check("prio_all_served", exp2[1].size(), 0);

        // Reset in the middle of BUSY abandons the transaction
        lat2[0] = 20;
        exp2[0].push_back('{0, 1'b0, 28'h0000DEF, mem_line(28'h0000DEF)});
        addr_a[0] = {28'h0000F00, 28'h0000DEF};
        rd_a[0] = 2'b01;
        tick(3);
        check("pre_rst_busy", mrd_a[0], 1);
        rd_a[0] = 2'b10;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_read", mrd_a[0], 0);
        check("midrst_mem_addr", maddr_a[0], 0);
        check("midrst_grant_id", gid_a[0], 0);
        check("midrst_ch_ready", rdy_a[0], 0);
        check("midrst_ch_rdata", rdata_a[0], 0);
        exp2[0].delete();
        exp2[0].push_back('{1, 1'b0, 28'h0000F00, mem_line(28'h0000F00)});
        base1 = done2[0][1];
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check("rst_hold_no_ready", rdy_a[0], 0);
        end
        lat2[0] = 1;
        rst_n = 1'b1;
        tick(1);
        check("post_rst_grant", mrd_a[0], 1);
        check("post_rst_gid", gid_a[0], 1);
        wait_done(0, 1, base1 + 1, "post_rst", w);
        rd_a[0] = 2'b00;
        tick(2);

        // Random traffic on the 4-channel instance
        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (active4[c]) begin
                    if (comp4[c] != seen4[c]) begin
                        seen4[c]   = comp4[c];
                        active4[c] = 1'b0;
                        rd4[c] = 1'b0;
                        wr4[c] = 1'b0;
                    end
                end else if (cyc < 1100 && $urandom_range(0, 99) < 35) begin
                    kind   = $urandom_range(0, 2);
                    t.ch   = c;
                    t.wr   = (kind != 0);
                    t.addr = 28'($urandom);
                    t.data = t.wr ? {$urandom, $urandom, $urandom, $urandom} : mem_line(t.addr);
                    exp4[c].push_back(t);
                    addr4[c*28 +: 28]   = t.addr;
                    wdata4[c*128 +: 128] = kind != 0 ? t.data : {4{32'h0BAD_0BAD}};
                    rd4[c] = (kind != 1);
                    wr4[c] = (kind != 0);
                    active4[c] = 1'b1;
                    issued4++;
                end
            end
            tick(1);
        end
        guard = 0;
        while ((active4[0] || active4[1] || active4[2] || active4[3]) && guard < 200) begin
            for (int c = 0; c < 4; c++) begin
                if (active4[c] && comp4[c] != seen4[c]) begin
                    seen4[c]   = comp4[c];
                    active4[c] = 1'b0;
                    rd4[c] = 1'b0;
                    wr4[c] = 1'b0;
                end
            end
            tick(1);
            guard++;
        end
        tick(3);
        sum4 = 0;
        for (int c = 0; c < 4; c++) begin
            sum4 += comp4[c];
            check("r4_queue_empty", exp4[c].size(), 0);
        end
        check("r4_all_completed", sum4, issued4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting cache channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 28, line address width (byte address bits [31:4]).
REQ-003 SHALL have parameter LINE_W, default 128, cache line data width.
REQ-004 SHALL have parameter PRIO_MODE, default 0, arbitration mode (0 = round-robin, 1 = fixed priority, channel 0 highest).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port ch_read, input, NUM_CH, per-channel line read request.
REQ-008 SHALL have port ch_write, input, NUM_CH, per-channel line write request.
REQ-009 SHALL have port ch_addr, input, NUM_CH*ADDR_W, per-channel line address; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port ch_wdata, input, NUM_CH*LINE_W, per-channel write line; channel i at [i*LINE_W +: LINE_W].
REQ-011 SHALL have port ch_rdata, output, LINE_W, read line broadcast to all channels.
REQ-012 SHALL have port ch_ready, output, NUM_CH, per-channel one-cycle completion pulse.
REQ-013 SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, LINE_W), to the single slow memory.
REQ-014 SHALL have ports mem_rdata (input, LINE_W) and mem_ready (input, 1), from the slow memory.
REQ-015 SHALL have port grant_id, output, $clog2(NUM_CH) (min 1), index of the channel owning the memory.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-017 IDLE: request vector = ch_read|ch_write; if nonzero, SHALL select winner, latch its index, addr, wdata, read/write kind, and go to BUSY; else stay in IDLE.
REQ-018 PRIO_MODE=0: winner SHALL be first requester searching from (last_grant+1) mod NUM_CH upward with wrap-around; last_grant updated on every grant.
REQ-019 PRIO_MODE=1: winner SHALL be lowest-index requester; last_grant still updated but unused.
REQ-020 A channel asserting both ch_read and ch_write SHALL be served as write only.
REQ-021 BUSY: mem_read/mem_write/mem_addr/mem_wdata SHALL be driven from registered latched values, stable for the entire BUSY state; exactly one of mem_read/mem_write high.
REQ-022 Request at IDLE cycle t SHALL produce mem_read or mem_write high from cycle t+1.
REQ-023 BUSY with mem_ready=1 at cycle m: SHALL capture mem_rdata (reads only) into ch_rdata register, drop mem_read/mem_write at m+1, go to RESP.
REQ-024 RESP (cycle m+1): ch_ready[grant_id] SHALL be 1, all other ch_ready bits 0; next state IDLE unconditionally.
REQ-025 ch_rdata SHALL hold last captured line until next read completion; write completions do not change it.
REQ-026 Requester deasserting its request while BUSY SHALL not abort the memory transaction; RESP pulse still issued.
REQ-027 mem_ready while IDLE or RESP SHALL be ignored.
REQ-028 Non-granted channels SHALL see ch_ready=0 and hold requests; no request SHALL be lost or starved (PRIO_MODE=0: any persistent request served within NUM_CH grants).
REQ-029 grant_id SHALL equal latched winner in BUSY and RESP, last value otherwise.
REQ-030 Minimum turnaround: IDLE to next IDLE SHALL be 2 cycles plus memory latency.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ch_ready=0, ch_rdata=0, grant_id=0, last_grant=NUM_CH-1 (channel 0 wins first round-robin grant).
REQ-032 Reset asserted mid-BUSY SHALL abandon the transaction with no ch_ready pulse; after release arbitration restarts from IDLE.

Verification
REQ-033 Single read: NUM_CH=2, ch_read=2'b01, ch_addr[0]=28'h0000123, memory ready after 4 cycles with 128'hA5...A5 -> mem_read high 1 cycle after request, mem_addr=28'h0000123, ch_ready=2'b01 one cycle after mem_ready, ch_rdata=128'hA5...A5.
REQ-034 Round-robin contention: PRIO_MODE=0, both channels read continuously from reset -> grant order 0,1,0,1; no channel granted twice consecutively.
REQ-035 Fixed priority: PRIO_MODE=1, both channels request continuously -> channel 0 granted every time; channel 1 granted only after channel 0 drops.
REQ-036 Write passthrough: ch_write=2'b10, ch_wdata[1]=128'h0123...CDEF -> mem_write=1, mem_wdata equal, ch_ready=2'b10, ch_rdata unchanged.
REQ-037 Reset mid-operation: rst_n low during BUSY -> all outputs zero immediately, no ch_ready pulse; after release, pending ch_read=2'b10 granted to channel 1 within 1 cycle.
REQ-038 Spurious mem_ready in IDLE with no requests -> no ch_ready, state stays IDLE; NUM_CH=4 random traffic -> every request completes exactly once.
